// File: rtl/ps2_key_tracker_if.sv
// Key-event stream between the PS/2 tracker and its consumer.
// The master presents the FIFO head; the slave accepts it with ev_ready.
interface ps2_key_tracker_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 receiver, E0/F0 prefix decoder, typematic filter and event FIFO.
// Emits clean make/break events and tracks the held key and press count.
module ps2_key_tracker #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  clr_flags,
  ps2_key_tracker_if.master     ev,
  output logic                  held,
  output logic [7:0]            held_code,
  output logic                  held_ext,
  output logic [CNT_W-1:0]      press_cnt,
  output logic                  overflow,
  output logic                  parity_err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Frame layout after 11 LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop
  function automatic logic frame_good(input logic [10:0] f);
    return (f[0] == 1'b0) && f[10] && (^f[9:1]);
  endfunction

  logic [2:0]      clk_sync, data_sync;
  logic            strobe;
  logic [10:0]     shreg;
  logic [10:0]     frame;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            byte_ok;
  logic [7:0]      byte_data;
  logic            bad_frame;

  assign frame     = {data_sync[2], shreg[10:1]};
  assign bad_frame = strobe && (bit_cnt == 4'd10) && !frame_good(frame);

  // Stage 0: synchronise and detect falling edges of ps2_clk
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '0;
      data_sync <= '0;
      strobe    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      strobe    <= clk_sync[2] & ~clk_sync[1];
    end
  end

  // Stage 1: bit assembly, frame check and idle timeout
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      byte_ok   <= 1'b0;
      byte_data <= '0;
    end else begin
      byte_ok <= 1'b0;
      if (strobe) begin
        shreg  <= frame;
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_good(frame)) begin
            byte_ok   <= 1'b1;
            byte_data <= frame[8:1];
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_LAST) begin
          bit_cnt <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Stage 2: prefix decoder, typematic filter, FIFO write
  state_t state_q, state_d;
  logic   ev_fire, ev_ext_d, ev_brk_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ev_fire  = 1'b0;
    ev_ext_d = (state_q == EXT) || (state_q == EXT_BRK);
    ev_brk_d = (state_q == BRK) || (state_q == EXT_BRK);
    if (byte_ok) begin
      case (byte_data)
        8'hE0: state_d = EXT;
        8'hF0: begin
          case (state_q)
            IDLE:    state_d = BRK;
            EXT:     state_d = EXT_BRK;
            default: state_d = state_q;
          endcase
        end
        default: begin
          ev_fire = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  logic key_match, is_repeat, push;
  assign key_match = (byte_data == held_code) && (ev_ext_d == held_ext);
  assign is_repeat = ev_fire && !ev_brk_d && held && key_match;
  assign push      = ev_fire && !is_repeat;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held      <= 1'b0;
      held_code <= '0;
      held_ext  <= 1'b0;
      press_cnt <= '0;
    end else if (push && !ev_brk_d) begin
      held      <= 1'b1;
      held_code <= byte_data;
      held_ext  <= ev_ext_d;
      press_cnt <= press_cnt + 1'b1;
    end else if (push && ev_brk_d && held && key_match) begin
      held <= 1'b0;
    end
  end

  logic [9:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        empty, full, pop, wr_en, ov_set;

  assign count  = wptr - rptr;
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign pop    = !empty && ev.ev_ready;
  assign wr_en  = push && (!full || pop);
  assign ov_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= {ev_ext_d, ev_brk_d, byte_data};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      overflow   <= ov_set    | (overflow   & ~clr_flags);
      parity_err <= bad_frame | (parity_err & ~clr_flags);
    end
  end

  logic [9:0] head;
  assign head        = mem[rptr[AW-1:0]];
  assign ev.ev_valid = !empty;
  assign ev.ev_code  = empty ? 8'h00 : head[7:0];
  assign ev.ev_ext   = empty ? 1'b0  : head[9];
  assign ev.ev_break = empty ? 1'b0  : head[8];

endmodule
